// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes stage: applies the inverse S-box to each of the 16 bytes of
// a 128-bit state and registers the result with one cycle of latency. The
// valid flag is registered alongside the data. Byte k of the state sits at
// bits [8k : 8k+7], with byte 0 at bits [0:7].
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [0:127] data_in,
    output logic         valid_out,
    output logic [0:127] data_out
);

    // Inverse S-box lookup for one byte.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [0:127] w_sub;
    logic [0:127] r_data;
    logic         r_valid;

    // One independent lookup per byte lane; lanes never interact.
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_lane
            assign w_sub[8*g +: 8] = inv_sbox(data_in[8*g +: 8]);
        end
    endgenerate

    // Output register: reset clears data and valid, otherwise capture every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= 128'h0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= w_sub;
            r_valid <= valid_in;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed testbench for inv_sub_bytes: known vectors, uniform states, lane
// ordering, valid gaps, reset behaviour and an exhaustive sweep of every byte
// value in every lane against a table derived from the forward S-box.
module tb_inv_sub_bytes;

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic [0:127] data_in;
    logic         valid_out;
    logic [0:127] data_out;

    int n_checks;
    int n_pass;

    logic [0:2047] fwd_flat;
    logic [7:0]    fwd_tab [256];
    logic [7:0]    inv_tab [256];

    inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one state, clock it in, and check the result.
    task automatic apply(input string tag, input logic v, input logic [0:127] d,
                         input logic [0:127] exp_d);
        valid_in = v;
        data_in  = d;
        tick();
        check_eq({tag, "_valid"}, {127'h0, valid_out}, {127'h0, v});
        if (v) check_eq({tag, "_data"}, data_out, exp_d);
    endtask

    logic [0:127] st_in;
    logic [0:127] st_exp;
    logic [7:0]   b;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        fwd_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) fwd_tab[i] = fwd_flat[8*i +: 8];
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];

        // Reset held for two cycles with live input.
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = 128'h5411f4b56bd9700e96a0902fa1bb9aa1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_valid", {127'h0, valid_out}, 128'h0);
            check_eq("rst_data", data_out, 128'h0);
        end
        rst = 1'b0;

        // Known vectors, back to back.
        apply("kv0", 1'b1, 128'h5411f4b56bd9700e96a0902fa1bb9aa1, 128'hfde3bad205e5d0d73547964ef1fe37f1);
        apply("kv1", 1'b1, 128'h3e175076b61c04678dfc2295f6a8bfc0, 128'hd1876c0f79c4300ab45594add66ff41f);
        apply("kv2", 1'b1, 128'hb415f8016858552e4bb6124c5f998a4c, 128'hc62fe109f75eedc3cc79395d84f9cf5d);

        // Uniform states.
        apply("all00", 1'b1, {16{8'h00}}, {16{8'h52}});
        apply("all63", 1'b1, {16{8'h63}}, {16{8'h00}});
        apply("allff", 1'b1, {16{8'hff}}, {16{8'h7d}});
        apply("mix", 1'b1, {8'h16, 8'h7c, 8'h01, 8'h54, 8'h11, 8'hf4, 8'hb5, 8'h00, {8{8'h63}}},
              {8'hff, 8'h01, 8'h09, 8'hfd, 8'he3, 8'hba, 8'hd2, 8'h52, {8{8'h00}}});

        // Byte-lane ordering.
        apply("lanes", 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
        for (int k = 0; k < 16; k++) begin
            st_in  = {16{8'h00}};
            st_exp = {16{8'h52}};
            st_in[8*k +: 8]  = 8'h01;
            st_exp[8*k +: 8] = 8'h09;
            apply($sformatf("lane%0d", k), 1'b1, st_in, st_exp);
        end

        // Valid gaps: 1,0,1,1,0.
        apply("gap0", 1'b1, 128'h3e175076b61c04678dfc2295f6a8bfc0, 128'hd1876c0f79c4300ab45594add66ff41f);
        apply("gap1", 1'b0, 128'h5411f4b56bd9700e96a0902fa1bb9aa1, 128'h0);
        apply("gap2", 1'b1, 128'hb415f8016858552e4bb6124c5f998a4c, 128'hc62fe109f75eedc3cc79395d84f9cf5d);
        apply("gap3", 1'b1, 128'h5411f4b56bd9700e96a0902fa1bb9aa1, 128'hfde3bad205e5d0d73547964ef1fe37f1);
        apply("gap4", 1'b0, {16{8'hff}}, 128'h0);

        // Mid-stream reset discards the state in flight.
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = {16{8'h63}};
        tick();
        check_eq("mrst_valid", {127'h0, valid_out}, 128'h0);
        check_eq("mrst_data", data_out, 128'h0);
        rst = 1'b0;
        apply("resume", 1'b1, 128'h5411f4b56bd9700e96a0902fa1bb9aa1, 128'hfde3bad205e5d0d73547964ef1fe37f1);

        // Exhaustive: every value reaches every lane; also round-trip through forward S-box.
        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 16; k++) begin
                b = 8'(v + k);
                st_in[8*k +: 8]  = b;
                st_exp[8*k +: 8] = inv_tab[b];
            end
            apply($sformatf("exh%0d", v), 1'b1, st_in, st_exp);
            for (int k = 0; k < 16; k++) st_exp[8*k +: 8] = fwd_tab[data_out[8*k +: 8]];
            check_eq($sformatf("rt%0d", v), st_exp, st_in);
        end

        valid_in = 1'b0;
        tick();
        check_eq("idle_valid", {127'h0, valid_out}, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes.md
Name: inv_sub_bytes

Overview:
- AES InvSubBytes stage for the decryption datapath, per FIPS-197 section 5.3.2.
- Applies the inverse S-box independently to each of the 16 bytes of a 128-bit state.
- Registered single-stage block with one cycle of latency and a valid flag carried alongside the data.
- Sits between InvShiftRows and AddRoundKey in the inverse cipher round.

Parameters:
- None. The state width is fixed at 128 bits and the byte count at 16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
valid_in  input  1  data_in carries a state this cycle
data_in  input  [0:127]  input state; byte k occupies bits [8k : 8k+7], byte 0 at bits [0:7] (MSB-first)
valid_out  output  1  data_out carries a transformed state
data_out  output  [0:127]  transformed state, same byte ordering as data_in

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - On a rising edge with rst=1: data_out <= 128'h0 and valid_out <= 0.
  - rst has priority over all other inputs.
  - A state in flight when rst is asserted is discarded.
- Transform: for k = 0..15, data_out byte k = InvSbox(data_in byte k).
  - InvSbox is the standard 256-entry AES inverse S-box, implemented as a combinational case/lookup function.
  - The same function is instantiated 16 times, one per byte lane.
  - No cross-byte dependence.
  - Required lookup values:
    - 00->52, 01->09, 16->ff, 63->00, 7c->01, ff->7d
    - 54->fd, 11->e3, f4->ba, b5->d2
- Latency: exactly 1 clock.
  - On each rising edge with rst=0: data_out <= InvSubBytes(data_in) and valid_out <= valid_in.
- Flow control: fully pipelined, one state accepted per cycle, no backpressure, no ready signal.
- Invalid cycles:
  - data_out is updated every non-reset cycle regardless of valid_in.
  - Consumers qualify data_out with valid_out only.
  - data_out content when valid_out=0 is don't-care for checking, except directly after reset, where it is 0.
- Inputs are pure bits; no X-propagation handling is required.
- No internal state other than the output registers.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with arbitrary data_in and valid_in=1 -> data_out=0 and valid_out=0; release rst -> the first result appears one edge later.
2. Known vectors, valid_in=1, one per cycle, back-to-back; each result appears one cycle later with valid_out=1:
   - 5411f4b56bd9700e96a0902fa1bb9aa1 -> fde3bad205e5d0d73547964ef1fe37f1
   - 3e175076b61c04678dfc2295f6a8bfc0 -> d1876c0f79c4300ab45594add66ff41f
   - b415f8016858552e4bb6124c5f998a4c -> c62fe109f75eedc3cc79395d84f9cf5d
3. Uniform states:
   - all-0x00 -> all-0x52
   - all-0x63 -> all-0x00
   - all-0xff -> all-0x7d
4. Byte-lane ordering: data_in = 000102...0f -> data_out = 5209 6ad5 3036 a538 bf40 a39e 81f3 d7fb; a single nonzero byte moved across each lane position produces its result in the same lane only.
5. Valid gaps: pattern valid_in = 1,0,1,1,0 -> valid_out reproduces the pattern delayed by one cycle, with the correct data on every valid cycle.
6. Mid-stream reset and exhaustive check:
   - Assert rst for one cycle while valid_in=1 -> the next valid_out=0 and data_out=0; the stream resumes correctly after release.
   - Exhaustive check: all 256 byte values in every lane against the FIPS-197 inverse S-box table, plus round-trip against a forward S-box model.
